// File: rtl/vector_ram_pkg.sv
// Shared types for the vector RAM read path: element address/length types
// and the reader state encoding.
package vector_ram_pkg;

    localparam int VRAM_LENGTH     = 32;
    localparam int VRAM_ADDR_WIDTH = $clog2(VRAM_LENGTH);

    typedef logic [VRAM_ADDR_WIDTH-1:0] addr_t;
    typedef logic [VRAM_ADDR_WIDTH:0]   len_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/vector_ram_if.sv
// Request/response port of vector_ram. The master side issues lane-parallel
// requests and consumes in-order read responses.
interface vector_ram_if
    import vector_ram_pkg::*;
#(
    parameter int ADDR_WIDTH  = VRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH  = 32,
    parameter int PARALLELISM = 4
);
    logic [ADDR_WIDTH-1:0] addr  [PARALLELISM];
    logic [DATA_WIDTH-1:0] wdata [PARALLELISM];
    logic                  write;
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] rdata [PARALLELISM];
    logic                  rvalid;
    logic                  rready;

    modport master (
        output addr, wdata, write, valid, rready,
        input  ready, rdata, rvalid
    );

    modport slave (
        input  addr, wdata, write, valid, rready,
        output ready, rdata, rvalid
    );
endinterface

// File: rtl/vector_ram_meta_fifo.sv
// Per-beat metadata queue ({last, keep}) that pairs each issued request with
// its in-order response. Push and pop may happen in the same cycle.
module vector_ram_meta_fifo
    import vector_ram_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_q;
    logic [PTR_W:0]   rd_q;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                   (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
    assign head  = mem[rd_q[PTR_W-1:0]];

    // Storage write on push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_q[PTR_W-1:0]] <= push_data;
        end
    end

    // Read/write pointers with a wrap bit to tell full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push)          wr_q <= wr_q + (PTR_W + 1)'(1);
            if (pop && !empty) rd_q <= rd_q + (PTR_W + 1)'(1);
        end
    end

endmodule

// File: rtl/vector_ram_reader.sv
// Command-driven read sequencer in front of vector_ram: splits a
// (base, len) command into lane-parallel read beats, limits requests in
// flight, and streams responses out with keep/last from the metadata FIFO.
//
//   state | meaning
//   IDLE  | waiting for a command, cmd_ready high
//   ISSUE | issuing read beats (responses may already flow out)
//   DRAIN | all beats issued, forwarding remaining responses
module vector_ram_reader
    import vector_ram_pkg::*;
#(
    parameter int  VECTOR_LENGTH   = 32,
    parameter int  DATA_WIDTH      = 32,
    parameter int  PARALLELISM     = 4,
    parameter int  MAX_OUTSTANDING = 4,
    localparam int ADDR_WIDTH      = $clog2(VECTOR_LENGTH)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [ADDR_WIDTH-1:0]             cmd_base,
    input  logic [ADDR_WIDTH:0]               cmd_len,
    vector_ram_if.master                      req,
    output logic [DATA_WIDTH*PARALLELISM-1:0] out_data,
    output logic [PARALLELISM-1:0]            out_keep,
    output logic                              out_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              done
);
    localparam int LANE_BITS = $clog2(PARALLELISM);
    localparam int OUTS_W    = $clog2(MAX_OUTSTANDING) + 1;
    localparam int BEAT_W    = ADDR_WIDTH + 2;

    state_t                  state_q, state_d;
    logic                    ready_q;
    logic                    done_q, done_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH:0]     idx_q;
    logic [ADDR_WIDTH:0]     len_q;
    logic [BEAT_W-1:0]       beats_left_q;
    logic [BEAT_W-1:0]       cmd_beats;
    logic [OUTS_W-1:0]       outstanding_q;
    logic                    cmd_fire, issue_fire, rsp_fire, issue_last;
    logic [PARALLELISM-1:0]  issue_keep;
    logic [PARALLELISM:0]    head;
    logic                    fifo_full, fifo_empty;

    // ready_q holds cmd_ready low until the first edge after reset release.
    assign cmd_ready  = (state_q == IDLE) && ready_q;
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign cmd_beats  = ({1'b0, cmd_len} + BEAT_W'(PARALLELISM - 1)) >> LANE_BITS;
    assign req.valid  = (state_q == ISSUE) &&
                        (outstanding_q < OUTS_W'(MAX_OUTSTANDING)) && !fifo_full;
    assign req.write  = 1'b0;
    assign issue_fire = req.valid && req.ready;
    assign issue_last = (beats_left_q == BEAT_W'(1));

    // Responses pass straight through; rready is held off when no metadata exists.
    assign out_valid  = req.rvalid && !fifo_empty;
    assign req.rready = out_ready && !fifo_empty;
    assign rsp_fire   = out_valid && out_ready;
    assign out_keep   = head[PARALLELISM-1:0];
    assign out_last   = head[PARALLELISM];
    assign done       = done_q;

    // Lane address generation, keep mask of the beat being issued, data unpacking.
    always_comb begin
        for (int i = 0; i < PARALLELISM; i++) begin
            req.addr[i]   = addr_q + ADDR_WIDTH'(i);
            req.wdata[i]  = '0;
            issue_keep[i] = ({1'b0, idx_q} + BEAT_W'(i)) < {1'b0, len_q};
            out_data[i*DATA_WIDTH +: DATA_WIDTH] = req.rdata[i];
        end
    end

    // Next-state and done pulse request.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    if (cmd_len == '0) done_d  = 1'b1;
                    else               state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (issue_fire && issue_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (rsp_fire && out_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, ready-after-reset flag and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= 1'b1;
            done_q  <= done_d;
        end
    end

    // Beat pointer: next lane-0 address, element index, and beats left (down-counter).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            idx_q        <= '0;
            len_q        <= '0;
            beats_left_q <= '0;
        end else if (cmd_fire) begin
            addr_q       <= cmd_base;
            idx_q        <= '0;
            len_q        <= cmd_len;
            beats_left_q <= cmd_beats;
        end else if (issue_fire) begin
            addr_q       <= addr_q + ADDR_WIDTH'(PARALLELISM);
            idx_q        <= idx_q + (ADDR_WIDTH + 1)'(PARALLELISM);
            beats_left_q <= beats_left_q - BEAT_W'(1);
        end
    end

    // Requests issued but not yet consumed downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_q <= '0;
        end else begin
            unique case ({issue_fire, rsp_fire})
                2'b10:   outstanding_q <= outstanding_q + OUTS_W'(1);
                2'b01:   outstanding_q <= outstanding_q - OUTS_W'(1);
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    vector_ram_meta_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (PARALLELISM + 1)
    ) u_meta_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (issue_fire),
        .push_data ({issue_last, issue_keep}),
        .pop       (rsp_fire),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A response with no matching metadata means the RAM returned an unrequested beat.
    rvalid_has_meta: assert property (@(posedge clk) disable iff (!rst_n)
        req.rvalid |-> !fifo_empty);

endmodule

// File: tb/tb_vector_ram_reader.sv
// Bench for vector_ram_reader: a one-cycle-latency RAM model, a bus monitor,
// and a per-command reference computed from base/len arithmetic.
module tb_vector_ram_reader;
    localparam int VL = 32;
    localparam int DW = 32;
    localparam int P  = 4;
    localparam int MO = 4;
    localparam int AW = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [AW-1:0]     cmd_base = '0;
    logic [AW:0]       cmd_len = '0;
    logic [DW*P-1:0]   out_data;
    logic [P-1:0]      out_keep;
    logic              out_last;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              done;

    always #5 clk = ~clk;

    vector_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PARALLELISM(P)) ram_if ();

    vector_ram_reader #(
        .VECTOR_LENGTH(VL), .DATA_WIDTH(DW), .PARALLELISM(P), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base(cmd_base), .cmd_len(cmd_len),
        .req(ram_if),
        .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .done(done)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit rand_rdy = 1'b0;

    logic [AW*P-1:0]   iss_q [$];
    logic [DW*P+P:0]   obs_q [$];
    logic [DW*P-1:0]   rsp_q [$];
    int   done_cnt = 0, done_cyc = -1, last_hs_cyc = -1, cmd_hs_cyc = -1, req_valid_cnt = 0;
    logic done_rdy = 1'b0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AW*P-1:0] bus_addr();
        logic [AW*P-1:0] a;
        for (int i = 0; i < P; i++) a[i*AW +: AW] = ram_if.addr[i];
        return a;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // RAM model: in-order responses, one cycle after acceptance, rdata = address.
    initial begin : ram_model
        logic fr, fs;
        logic [AW*P-1:0] a;
        logic [DW*P-1:0] rd;
        ram_if.ready  = 1'b0;
        ram_if.rvalid = 1'b0;
        for (int i = 0; i < P; i++) ram_if.rdata[i] = '0;
        forever begin
            @(negedge clk);
            fr = rst_n && ram_if.valid && ram_if.ready;
            fs = rst_n && ram_if.rvalid && ram_if.rready;
            a  = bus_addr();
            @(posedge clk);
            #1;
            if (!rst_n) begin
                rsp_q.delete();
            end else begin
                if (fs && rsp_q.size() != 0) void'(rsp_q.pop_front());
                if (fr) begin
                    for (int i = 0; i < P; i++) rd[i*DW +: DW] = DW'(a[i*AW +: AW]);
                    rsp_q.push_back(rd);
                end
            end
            ram_if.rvalid = (rsp_q.size() != 0);
            for (int i = 0; i < P; i++)
                ram_if.rdata[i] = (rsp_q.size() != 0) ? rsp_q[0][i*DW +: DW] : '0;
            if (rand_rdy) begin
                ram_if.ready = ($urandom % 4) != 0;
                out_ready    = ($urandom % 3) != 0;
            end
        end
    end

    // Bus monitor, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (ram_if.valid) req_valid_cnt++;
            if (ram_if.valid && ram_if.ready) begin
                iss_q.push_back(bus_addr());
                check("write_low", ram_if.write, 1'b0);
            end
            if (out_valid && out_ready) begin
                obs_q.push_back({out_last, out_keep, out_data});
                if (out_last) last_hs_cyc = cyc;
            end
            if (cmd_valid && cmd_ready) cmd_hs_cyc = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                done_rdy = cmd_ready;
            end
        end
    end

    // Reference: beat k lane i reads element k*P+i at (base+k*P+i) mod VL.
    task automatic check_cmd(input int base, input int len);
        int beats;
        int e, a;
        logic [AW*P-1:0] ea;
        logic [P-1:0]    ek;
        logic [DW*P-1:0] ed, od;
        logic [DW*P+P:0] ob;
        beats = (len + P - 1) / P;
        check("issue_count", iss_q.size(), beats);
        check("beat_count", obs_q.size(), beats);
        for (int k = 0; k < beats; k++) begin
            for (int i = 0; i < P; i++) begin
                e = k * P + i;
                a = (base + e) % VL;
                ea[i*AW +: AW] = AW'(a);
                ek[i] = (e < len);
                ed[i*DW +: DW] = ek[i] ? DW'(a) : '0;
            end
            if (k < iss_q.size()) check("issue_addr", iss_q[k], ea);
            if (k < obs_q.size()) begin
                ob = obs_q[k];
                od = ob[DW*P-1:0];
                for (int i = 0; i < P; i++) if (!ek[i]) od[i*DW +: DW] = '0;
                check("out_keep", ob[DW*P +: P], ek);
                check("out_last", ob[DW*P+P], (k == beats - 1));
                check("out_data", od, ed);
            end
        end
    endtask

    task automatic run_cmd(input int base, input int len, input int hold);
        int w;
        iss_q.delete(); obs_q.delete();
        done_cnt = 0; req_valid_cnt = 0;
        done_cyc = -1; last_hs_cyc = -1; cmd_hs_cyc = -1;
        w = 0;
        while (!cmd_ready && w < 100) begin @(negedge clk); w++; end
        check("cmd_ready_idle", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_base  = AW'(base);
        cmd_len   = (AW + 1)'(len);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check("bp_issued", iss_q.size(), MO);
            check("bp_valid_low", ram_if.valid, 1'b0);
            check("bp_no_beats", obs_q.size(), 0);
            @(posedge clk); #1;
            out_ready = 1'b1;
        end
        w = 0;
        while (done_cnt == 0 && w < 2000) begin @(negedge clk); w++; end
        check("done_seen", (done_cnt != 0), 1'b1);
        repeat (3) @(negedge clk);
        check("done_once", done_cnt, 1);
        check("done_time", done_cyc, (len == 0) ? cmd_hs_cyc + 1 : last_hs_cyc + 1);
        check("done_cmd_ready", done_rdy, 1'b1);
        if (len == 0) check("zero_no_req", req_valid_cnt, 0);
        check_cmd(base, len);
    endtask

    task automatic check_reset_outs();
        check("rst_outs", {cmd_ready, ram_if.valid, ram_if.rready, out_valid, done}, 5'b0);
    endtask

    task automatic abort_cmd();
        int w;
        iss_q.delete(); obs_q.delete();
        @(posedge clk); #1;
        ram_if.ready = 1'b1;
        out_ready    = 1'b0;
        cmd_valid    = 1'b1;
        cmd_base     = AW'(9);
        cmd_len      = (AW + 1)'(32);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        w = 0;
        while (iss_q.size() < 2 && w < 50) begin @(negedge clk); w++; end
        check("abort_two_issued", iss_q.size(), 2);
        @(posedge clk); #2;
        rst_n = 1'b0;
        rsp_q.delete();
        ram_if.rvalid = 1'b0;
        done_cnt = 0;
        repeat (3) begin @(negedge clk); check_reset_outs(); end
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        check("rel_ready_low", cmd_ready, 1'b0);
        @(negedge clk);
        check("rel_ready_high", cmd_ready, 1'b1);
        repeat (20) @(negedge clk);
        check("abort_no_done", done_cnt, 0);
    endtask

    initial begin
        repeat (3) begin @(negedge clk); check_reset_outs(); end
        #1;
        rst_n = 1'b1;
        #1;
        check("init_ready_low", cmd_ready, 1'b0);
        @(negedge clk);
        check("init_ready_high", cmd_ready, 1'b1);
        ram_if.ready = 1'b1;
        out_ready    = 1'b1;

        run_cmd(0, 32, 0);
        run_cmd(4, 6, 0);
        run_cmd(30, 4, 0);
        run_cmd(7, 0, 0);

        @(posedge clk); #1;
        out_ready = 1'b0;
        run_cmd(0, 32, 20);

        abort_cmd();
        run_cmd(12, 17, 0);

        rand_rdy = 1'b1;
        for (int n = 0; n < 30; n++) run_cmd(int'($urandom % VL), int'($urandom_range(0, VL)), 0);
        rand_rdy = 1'b0;
        @(posedge clk); #1;
        ram_if.ready = 1'b1;
        out_ready    = 1'b1;
        run_cmd(31, 32, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule
